// File: rtl/conv_accumulator_pkg.sv
// Shared types and constants for the convolution accumulator stage:
// controller states, activation encodings and the ReLU6 ceiling helper.
package conv_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_RELU6 = 2'b10;

    // 6.0 expressed in the fixed-point format with frac_bits fractional bits
    function automatic int relu6_limit(input int frac_bits);
        return 32'sd6 <<< frac_bits;
    endfunction

endpackage

// File: rtl/conv_accumulator_acc_sat_act.sv
// Combinational saturation of the wide accumulator back to WIDTH bits,
// followed by the selected activation (none / ReLU / ReLU6).
module acc_sat_act
    import conv_accumulator_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int ACC_WIDTH = 19,
    parameter int FRAC_BITS = 7
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic        [1:0]           i_act_sel,
    output logic signed [WIDTH-1:0]     o_result
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] RELU6_MAX = WIDTH'(relu6_limit(FRAC_BITS));

    logic signed [WIDTH-1:0] w_sat;

    // Clamp the accumulator onto the signed WIDTH-bit rails
    always_comb begin
        w_sat = i_acc[WIDTH-1:0];
        if (i_acc > SAT_MAX) begin
            w_sat = SAT_MAX[WIDTH-1:0];
        end else if (i_acc < SAT_MIN) begin
            w_sat = SAT_MIN[WIDTH-1:0];
        end else begin
            w_sat = i_acc[WIDTH-1:0];
        end
    end

    // Apply the activation; the unused 2'b11 code behaves as pass-through
    always_comb begin
        o_result = w_sat;
        case (i_act_sel)
            ACT_RELU: begin
                if (w_sat[WIDTH-1]) begin
                    o_result = {WIDTH{1'b0}};
                end else begin
                    o_result = w_sat;
                end
            end
            ACT_RELU6: begin
                if (w_sat[WIDTH-1]) begin
                    o_result = {WIDTH{1'b0}};
                end else if (w_sat > RELU6_MAX) begin
                    o_result = RELU6_MAX;
                end else begin
                    o_result = w_sat;
                end
            end
            ACT_NONE: o_result = w_sat;
            default:  o_result = w_sat;
        endcase
    end

endmodule

// File: rtl/conv_accumulator.sv
// Kernel-window accumulator: adds up to MAX_LEN signed products onto a bias,
// then saturates, activates and holds the result in a one-entry output register.
module conv_accumulator
    import conv_accumulator_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int FRAC_BITS = 7,
    parameter int MAX_LEN   = 9,
    localparam int ACC_WIDTH = WIDTH + $clog2(MAX_LEN) + 1,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic signed [WIDTH-1:0] bias,
    input  logic [1:0]              act_sel,
    input  logic signed [WIDTH-1:0] prod,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    state_e r_state;
    state_e w_next_state;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [LEN_W-1:0]            r_count;
    logic [LEN_W-1:0]            r_len;
    logic [1:0]                  r_act_sel;
    logic signed [WIDTH-1:0]     r_out_data;
    logic                        r_out_valid;
    logic                        r_prod_ready;
    logic                        r_busy;

    logic [LEN_W-1:0]            w_len_clamped;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_acc_sum;
    logic signed [ACC_WIDTH-1:0] w_sat_acc;
    logic [1:0]                  w_sat_act;
    logic signed [WIDTH-1:0]     w_result;
    logic                        w_beat;
    logic                        w_last;

    assign w_len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign w_bias_ext    = {{(ACC_WIDTH-WIDTH){bias[WIDTH-1]}}, bias};
    assign w_prod_ext    = {{(ACC_WIDTH-WIDTH){prod[WIDTH-1]}}, prod};
    assign w_acc_sum     = r_acc + w_prod_ext;
    assign w_beat        = prod_valid & r_prod_ready;
    assign w_last        = w_beat & (r_count == (r_len - LEN_W'(1)));

    // A zero-length window finishes from IDLE, so the result path sees the bias there
    always_comb begin
        w_sat_acc = w_bias_ext;
        w_sat_act = act_sel;
        if (r_state == ST_ACCUM) begin
            w_sat_acc = w_acc_sum;
            w_sat_act = r_act_sel;
        end else begin
            w_sat_acc = w_bias_ext;
            w_sat_act = act_sel;
        end
    end

    acc_sat_act #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_acc_sat_act (
        .i_acc     (w_sat_acc),
        .i_act_sel (w_sat_act),
        .o_result  (w_result)
    );

    // Window sequencing: intake, then hold the result until it is taken
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (w_len_clamped == {LEN_W{1'b0}}) ? ST_OUTPUT : ST_ACCUM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_last) begin
                    w_next_state = ST_OUTPUT;
                end else begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OUTPUT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; handshake flags are decoded from the next state so they leave registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_prod_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_prod_ready <= (w_next_state == ST_ACCUM);
            r_out_valid  <= (w_next_state == ST_OUTPUT);
            r_busy       <= (w_next_state != ST_IDLE);
        end
    end

    // Accumulator, tap counter, latched window settings and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= {ACC_WIDTH{1'b0}};
            r_count    <= {LEN_W{1'b0}};
            r_len      <= {LEN_W{1'b0}};
            r_act_sel  <= ACT_NONE;
            r_out_data <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc     <= w_bias_ext;
                        r_count   <= {LEN_W{1'b0}};
                        r_len     <= w_len_clamped;
                        r_act_sel <= act_sel;
                        if (w_len_clamped == {LEN_W{1'b0}}) begin
                            r_out_data <= w_result;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_acc_sum;
                        r_count <= r_count + LEN_W'(1);
                        if (w_last) begin
                            r_out_data <= w_result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign prod_ready = r_prod_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed scenarios plus randomized
// windows compared against a plain-arithmetic reference model.
module tb_conv_accumulator;

    localparam int WIDTH = 14;
    localparam int LEN_W = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        len = 4'd0;
    logic signed [WIDTH-1:0] bias = 14'sd0;
    logic [1:0]              act_sel = 2'b00;
    logic signed [WIDTH-1:0] prod = 14'sd0;
    logic                    prod_valid = 1'b0;
    logic                    prod_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    busy;

    int checks = 0;
    int failures = 0;

    conv_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .bias       (bias),
        .act_sel    (act_sel),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: integer sum of bias and first min(len,9) products, clamp, activate
    function automatic int model(input int b, input int p[$], input int l, input int a);
        int s = b;
        int n = (l > 9) ? 9 : l;
        for (int i = 0; i < n; i++) s += p[i];
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        if (a == 1 && s < 0) s = 0;
        if (a == 2) begin
            if (s < 0) s = 0;
            if (s > 768) s = 768;
        end
        return s;
    endfunction

    task automatic start_window(input int l, input int b, input int a);
        @(negedge clk);
        start = 1'b1; len = LEN_W'(l); bias = WIDTH'(b); act_sel = 2'(a);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers products; pat gives the valid pattern first, then gaps are random
    task automatic feed(input int p[$], input bit pat[$], input int gap_pct, output bit timeout);
        int idx = 0;
        int pi = 0;
        int guard = 0;
        bit give;
        bit rdy;
        timeout = 1'b0;
        while (idx < p.size() && guard < 300) begin
            if (pi < pat.size()) begin
                give = pat[pi];
                pi++;
            end else begin
                give = ($urandom_range(99) >= gap_pct);
            end
            prod_valid = give;
            prod = WIDTH'(p[idx]);
            rdy = prod_ready;
            @(negedge clk);
            if (give && rdy) idx++;
            guard++;
        end
        prod_valid = 1'b0;
        if (idx < p.size()) timeout = 1'b1;
    endtask

    task automatic take_output(output int data, output bit timeout);
        int g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        timeout = !out_valid;
        data = int'($signed(out_data));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b0 || busy !== 1'b0 || out_data !== 14'sd0) begin
            failures++;
            $display("FAIL reset_values got v=%b r=%b b=%b d=%0d want 0 0 0 0",
                     out_valid, prod_ready, busy, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int p[$] = '{128, 256, -64};
        bit pat[$] = '{1, 1, 1};
        bit to;
        int d;
        start_window(3, 0, 0);
        checks++;
        if (prod_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready got r=%b b=%b want 1 1", prod_ready, busy);
        end
        feed(p, pat, 0, to);
        checks++;
        if (to || out_valid !== 1'b1 || int'($signed(out_data)) !== model(0, p, 3, 0)) begin
            failures++;
            $display("FAIL basic_result got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, model(0, p, 3, 0));
        end
        checks++;
        if (prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_out got %b want 0", prod_ready);
        end
        take_output(d, to);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got v=%b b=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_saturation();
        int hi[$] = '{8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191};
        int lo[$] = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
        bit none[$];
        bit to;
        int d;
        start_window(9, 8191, 0);
        feed(hi, none, 0, to);
        take_output(d, to);
        checks++;
        if (to || d !== model(8191, hi, 9, 0)) begin
            failures++;
            $display("FAIL sat_high got %0d want %0d", d, model(8191, hi, 9, 0));
        end
        start_window(9, -8192, 0);
        feed(lo, none, 0, to);
        take_output(d, to);
        checks++;
        if (to || d !== model(-8192, lo, 9, 0)) begin
            failures++;
            $display("FAIL sat_low got %0d want %0d", d, model(-8192, lo, 9, 0));
        end
    endtask

    task automatic test_activation();
        int pa[3][$];
        int acts[3] = '{1, 2, 2};
        bit none[$];
        bit to;
        int d;
        pa[0] = '{-100, -100};
        pa[1] = '{600, 400};
        pa[2] = '{200, 300};
        for (int k = 0; k < 3; k++) begin
            start_window(2, 0, acts[k]);
            feed(pa[k], none, 0, to);
            take_output(d, to);
            checks++;
            if (to || d !== model(0, pa[k], 2, acts[k])) begin
                failures++;
                $display("FAIL activation_%0d got %0d want %0d", k, d, model(0, pa[k], 2, acts[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        int p[$] = '{100, -30};
        bit none[$];
        bit to;
        logic signed [WIDTH-1:0] held;
        start_window(2, 0, 0);
        feed(p, none, 0, to);
        held = out_data;
        checks++;
        if (to || int'($signed(held)) !== model(0, p, 2, 0)) begin
            failures++;
            $display("FAIL bp_value got %0d want %0d", held, model(0, p, 2, 0));
        end
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            len = LEN_W'($urandom_range(1, 9));
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || prod_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b d=%0d r=%b b=%b want 1 %0d 0 1",
                         c, out_valid, out_data, prod_ready, busy, held);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_transfer got v=%b b=%b want 0 0", out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || prod_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_start_ignored got b=%b r=%b v=%b want 0 0 0", busy, prod_ready, out_valid);
        end
    endtask

    task automatic test_gaps_and_len0();
        int p[$] = '{10, 20, 30, 40};
        bit pat[$] = '{1, 0, 1, 0, 0, 1, 1};
        int e[$];
        bit to;
        int d;
        start_window(4, 0, 0);
        feed(p, pat, 0, to);
        take_output(d, to);
        checks++;
        if (to || d !== model(0, p, 4, 0)) begin
            failures++;
            $display("FAIL gaps got %0d want %0d", d, model(0, p, 4, 0));
        end
        start_window(0, -50, 1);
        checks++;
        if (out_valid !== 1'b1 || int'($signed(out_data)) !== model(-50, e, 0, 1) || prod_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0 got v=%b d=%0d r=%b want 1 %0d 0", out_valid, out_data, prod_ready,
                     model(-50, e, 0, 1));
        end
        take_output(d, to);
    endtask

    task automatic test_reset_midwindow();
        int p[$] = '{500, 600};
        int q[$] = '{77};
        bit none[$];
        bit to;
        int d;
        start_window(5, 0, 0);
        feed(p, none, 0, to);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b0 || busy !== 1'b0 || out_data !== 14'sd0) begin
            failures++;
            $display("FAIL midreset got v=%b r=%b b=%b d=%0d want 0 0 0 0", out_valid, prod_ready, busy, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        start_window(1, 0, 0);
        feed(q, none, 0, to);
        take_output(d, to);
        checks++;
        if (to || d !== model(0, q, 1, 0)) begin
            failures++;
            $display("FAIL after_reset got %0d want %0d", d, model(0, q, 1, 0));
        end
    endtask

    task automatic test_back_to_back();
        bit none[$];
        bit to;
        int d;
        for (int w = 0; w < 30; w++) begin
            int l = $urandom_range(0, 15);
            int b = $urandom_range(0, 16383) - 8192;
            int a = $urandom_range(0, 3);
            int n = (l > 9) ? 9 : l;
            int p[$];
            for (int i = 0; i < n; i++) p.push_back($urandom_range(0, 16383) - 8192);
            start_window(l, b, a);
            if (n > 0) feed(p, none, 30, to);
            take_output(d, to);
            checks++;
            if (to || d !== model(b, p, l, a)) begin
                failures++;
                $display("FAIL random_%0d len=%0d act=%0d got %0d want %0d", w, l, a, d, model(b, p, l, a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_activation();
        test_backpressure();
        test_gaps_and_len0();
        test_reset_midwindow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
